// File: rtl/intersection_pkg.sv
// Shared types for the intersection sequencer: phase encodings and lamp bundle.
package intersection_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    WALK      = 3'd6
  } phase_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter paced by the tick strobe; expired_o flags count==0.
module phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturates at zero so a held phase keeps reporting expiry on every tick.
  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (tick_i && count_q != '0)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/intersection_sequencer.sv
// Two-way traffic light sequencer with optional pedestrian WALK phase,
// enabled by defining INTERSECTION_PED_WALK_EN.
module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 6,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               ew_car,
  input  logic               ped_req,
  output logic               ns_red,
  output logic               ns_yellow,
  output logic               ns_green,
  output logic               ew_red,
  output logic               ew_yellow,
  output logic               ew_green,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);

  phase_e           state_q, state_d;
  logic             expired, advance, load;
  logic [CNT_W-1:0] load_val;
  logic             ped_pending;
  lamp_t            ns_lamp, ew_lamp;

`ifdef INTERSECTION_PED_WALK_EN
  logic ped_q, ped_d;

  // Entering WALK clears the request; presses during WALK are discarded.
  always_comb begin
    ped_d = ped_q;
    if (state_d == WALK && state_q != WALK)
      ped_d = 1'b0;
    else if (state_q != WALK && ped_req)
      ped_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ped_q <= 1'b0;
    else       ped_q <= ped_d;
  end

  assign ped_pending = ped_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
`endif

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_LD)) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .tick_i     (tick),
    .load_i     (load),
    .load_val_i (load_val),
    .expired_o  (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ALL_RED_A;
    else       state_q <= state_d;
  end

  assign advance = tick && expired;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      unique case (state_q)
        ALL_RED_A: state_d = NS_GREEN;
        NS_GREEN:  if (ew_car || ped_pending) state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B: state_d = ew_car ? EW_GREEN : (ped_pending ? WALK : ALL_RED_A);
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ped_pending ? WALK : ALL_RED_A;
        WALK:      state_d = ALL_RED_A;
        default:   state_d = ALL_RED_A;
      endcase
    end
  end

  // A held NS_GREEN never reloads, so the counter stays parked at zero.
  assign load = (state_d != state_q);

  always_comb begin
    unique case (state_d)
      NS_GREEN, EW_GREEN:   load_val = GREEN_LD;
      NS_YELLOW, EW_YELLOW: load_val = YELLOW_LD;
      WALK:                 load_val = WALK_LD;
      default:              load_val = ALLRED_LD;
    endcase
  end

  always_comb begin
    ns_lamp = LAMP_RED;
    ew_lamp = LAMP_RED;
    walk    = 1'b0;
    unique case (state_q)
      NS_GREEN:  ns_lamp = LAMP_GREEN;
      NS_YELLOW: ns_lamp = LAMP_YELLOW;
      EW_GREEN:  ew_lamp = LAMP_GREEN;
      EW_YELLOW: ew_lamp = LAMP_YELLOW;
      WALK:      walk    = 1'b1;
      default: ;
    endcase
  end

  assign {ns_red, ns_yellow, ns_green} = ns_lamp;
  assign {ew_red, ew_yellow, ew_green} = ew_lamp;
  assign phase = state_q;

endmodule

// File: doc/intersection_sequencer.md
INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameter GREEN_TICKS, default 8: minimum green duration in ticks, legal range 1..2^CNT_W.
REQ-002 Parameter YELLOW_TICKS, default 3: yellow duration in ticks, legal range 1..2^CNT_W.
REQ-003 Parameter ALLRED_TICKS, default 1: all-red clearance duration in ticks, legal range 1..2^CNT_W.
REQ-004 Parameter WALK_TICKS, default 6: pedestrian walk duration in ticks, legal range 1..2^CNT_W.
REQ-005 Parameter CNT_W, default 8: phase counter width.
REQ-006 Port list SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  time-base strobe, one clk wide.
- ew_car  in  1  east-west vehicle present, level.
- ped_req  in  1  pedestrian button, level or pulse.
- ns_red, ns_yellow, ns_green  out  1 each  north-south lamps.
- ew_red, ew_yellow, ew_green  out  1 each  east-west lamps.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding.

Function
REQ-007 States SHALL be ALL_RED_A, NS_GREEN, NS_YELLOW, ALL_RED_B, EW_GREEN, EW_YELLOW, WALK.
REQ-008 Phase counter SHALL load duration-1 on state entry, decrement only on cycles with tick=1, and leave a state only on a cycle with tick=1 and count=0; each state lasts exactly its duration in ticks.
REQ-009 Transitions SHALL be:
- ALL_RED_A->NS_GREEN.
- NS_GREEN->NS_YELLOW when expired and (ew_car=1 or ped_pending=1); otherwise hold with count at 0.
- NS_YELLOW->ALL_RED_B.
- ALL_RED_B->EW_GREEN when ew_car=1, else ->WALK when ped_pending=1, else ->ALL_RED_A.
- EW_GREEN->EW_YELLOW.
- EW_YELLOW->WALK when ped_pending=1, else ->ALL_RED_A.
- WALK->ALL_RED_A.
REQ-010 ped_pending SHALL set on any clk edge with ped_req=1 and clear on the edge entering WALK; on that edge, clear wins and ped_req is ignored for the whole of WALK.
REQ-011 Lamp outputs SHALL decode from the state register only, with no combinational path from inputs; exactly one lamp per direction is lit.
REQ-012 WALK and both ALL_RED states SHALL drive both directions red; walk=1 only in WALK.
REQ-013 tick=0 SHALL freeze counter and state; ew_car and ped_req are sampled only as REQ-009/REQ-010 specify.

Reset
REQ-014 reset=1 SHALL force state ALL_RED_A, count ALLRED_TICKS-1, ped_pending 0, ns_red=ew_red=1, all other lamps 0, walk 0, immediately and asynchronously, including mid-phase.

Configuration
REQ-015 With macro INTERSECTION_PED_WALK_EN defined, WALK, ped_pending and walk behave as above.
REQ-016 Without INTERSECTION_PED_WALK_EN, WALK and ped_pending SHALL be removed, ped_req is ignored, walk is tied 0, and every WALK branch in REQ-009 takes its else-branch.

Structure
REQ-017 Package intersection_pkg SHALL hold the state enum and its phase encodings.
REQ-018 Sub-module phase_timer (loadable CNT_W down-counter with tick enable and expired flag) SHALL implement REQ-008.

Verification (GREEN=4, YELLOW=2, ALLRED=1, WALK=3, tick=1 every cycle)
REQ-019 Reset release with ew_car=1, ped_req=0 -> phases ALL_RED_A 1, NS_GREEN 4, NS_YELLOW 2, ALL_RED_B 1, EW_GREEN 4, EW_YELLOW 2 cycles, then repeat.
REQ-020 ew_car=0, ped_req=0 -> NS_GREEN held indefinitely; raising ew_car after 10 cycles -> NS_YELLOW on next cycle.
REQ-021 One-cycle ped_req pulse during EW_GREEN -> WALK for 3 cycles after EW_YELLOW, walk=1, all lamps red, then ALL_RED_A; a second pulse during WALK produces no further WALK.
REQ-022 tick every 4th cycle -> NS_GREEN lasts 16 clk cycles; tick=0 held -> no state change.
REQ-023 reset asserted mid-EW_GREEN -> same cycle ns_red=ew_red=1, walk=0, phase=ALL_RED_A, ped_pending cleared.
REQ-024 Build without INTERSECTION_PED_WALK_EN, ped_req held 1, ew_car=0 -> NS_GREEN held, walk never 1.
